// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and radix-2 restoring divide, 32 cycles each.
// Divide-by-zero and signed overflow are resolved at acceptance without iterating.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle 33x33 signed multiplier
// for MUL/MULH/MULHSU/MULHU; divide stays iterative).
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [31:0] r_b;        // multiplicand / divisor magnitude
    logic        r_neg;      // negate the final result
    logic [63:0] r_acc;      // mul: {partial product, multiplier}; div: {0, dividend/quotient}
    logic [31:0] r_rem;      // divide partial remainder
    logic        r_done;
    logic [31:0] r_result;

    // Operand decode at acceptance
    logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_div_zero, w_div_ovf, w_special;
    logic [31:0] w_special_res;

    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed & op_a[31];
    assign w_b_neg    = w_b_signed & op_b[31];
    assign w_a_mag    = w_a_neg ? (~op_a + 32'd1) : op_a;
    assign w_b_mag    = w_b_neg ? (~op_b + 32'd1) : op_b;
    // Remainder takes the dividend's sign; product and quotient take sa^sb
    assign w_neg      = (funct3[2:1] == 2'b11) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = funct3[2] && (op_b == 32'd0);
    assign w_div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                        (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                      : (funct3[1] ? 32'd0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] w_fast_a, w_fast_b;
    logic        [63:0] w_fast_prod;
    logic        [31:0] w_fast_res;
    assign w_fast_a    = $signed({w_a_neg, op_a});
    assign w_fast_b    = $signed({w_b_neg, op_b});
    assign w_fast_prod = 64'(w_fast_a * w_fast_b);
    assign w_fast_res  = (funct3 == 3'b000) ? w_fast_prod[31:0] : w_fast_prod[63:32];
`endif

    // One iteration step of each datapath
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift, w_div_trial;
    logic        w_div_ok;
    logic [31:0] w_rem_next, w_quo_next;
    logic [63:0] w_acc_next;

    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next  = {w_mul_sum, r_acc[31:1]};
    assign w_div_shift = {r_rem, r_acc[31]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_div_trial[32];
    // Both candidates are below the divisor here, so 32 bits always suffice
    assign w_rem_next  = w_div_ok ? w_div_trial[31:0] : w_div_shift[31:0];
    assign w_quo_next  = {r_acc[30:0], w_div_ok};
    assign w_acc_next  = r_funct3[2] ? {32'd0, w_quo_next} : w_mul_next;

    // Final sign fix and result select, using the values of the last iteration
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix, w_rem_fix;
    logic [31:0] w_final;

    assign w_prod_fix = r_neg ? (~w_mul_next + 64'd1) : w_mul_next;
    assign w_quo_fix  = r_neg ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_fix  = r_neg ? (~w_rem_next + 32'd1) : w_rem_next;

    // Pick the architected output field for the latched operation
    always_comb begin
        w_final = w_rem_fix;
        case (r_funct3)
            3'b000:                 w_final = w_prod_fix[31:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[63:32];
            3'b100, 3'b101:         w_final = w_quo_fix;
            default:                w_final = w_rem_fix;
        endcase
    end

    // Control FSM with datapath registers and registered done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_funct3 <= 3'd0;
            r_b      <= 32'd0;
            r_neg    <= 1'b0;
            r_acc    <= 64'd0;
            r_rem    <= 32'd0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_funct3 <= funct3;
                        r_cnt    <= 5'd0;
                        r_neg    <= w_neg;
                        r_b      <= w_b_mag;
                        r_acc    <= {32'd0, w_a_mag};
                        r_rem    <= 32'd0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
`endif
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall is combinational so it covers the acceptance cycle; forced low in reset
    assign busy   = rst_n & (((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC));
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit: multiply, divide, special cases,
// back-to-back issue, flush and asynchronous reset behaviour.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Issue one operation at the next edge; cycle 0 is the acceptance cycle.
    // Records the done cycle, the result, busy-profile deviations and done one cycle later.
    task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input bit keep, output int dcyc, output logic [31:0] res,
                            output int berr, output logic done_after);
        dcyc = -1;
        res = 32'hxxxx_xxxx;
        berr = 0;
        done_after = 1'bx;
        @(posedge clk); #1;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        if (busy !== 1'b1) berr++;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dcyc = c;
                res = result;
                if (busy !== 1'b0) berr++;
                break;
            end
            if (busy !== 1'b1) berr++;
        end
        if (!keep) begin
            start = 1'b0;
            @(posedge clk); #1;
            done_after = done;
        end
    endtask

    task automatic test_reset();
        start = 1'b1; funct3 = 3'b100; op_a = 32'd5; op_b = 32'd0;
        #2;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
        n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h expected 00000000", result); end
        $display("[TB] reset: busy=%b done=%b result=%h", busy, done, result);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_release_done got %b expected 0", done); end
    endtask

    task automatic run_table(input vec_t v);
        int dcyc, berr;
        logic [31:0] res;
        logic da;
        issue_op(v.f, v.a, v.b, 1'b0, dcyc, res, berr, da);
        $display("[TB] %s f3=%0d a=%h b=%h -> result=%h done_cycle=%0d", v.name, v.f, v.a, v.b, res, dcyc);
        n_tests++; if (dcyc !== v.lat) begin n_fail++; $display("FAIL %s_latency got %0d expected %0d", v.name, dcyc, v.lat); end
        n_tests++; if (res !== v.exp) begin n_fail++; $display("FAIL %s_result got %h expected %h", v.name, res, v.exp); end
        n_tests++; if (berr !== 0) begin n_fail++; $display("FAIL %s_busy_profile got %0d bad cycles expected 0", v.name, berr); end
        n_tests++; if (da !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got done=%b after done expected 0", v.name, da); end
    endtask

    task automatic test_mul();
        vec_t v[4];
        v[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3"};
        v[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min"};
        v[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max"};
        v[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_max"};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_div();
        vec_t v[4];
        v[0] = '{3'b100, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFD, 33, "div_-7/2"};
        v[1] = '{3'b110, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFF, 33, "rem_-7/2"};
        v[2] = '{3'b101, 32'd100,       32'd7,   32'd14,        33, "divu_100/7"};
        v[3] = '{3'b111, 32'd100,       32'd7,   32'd2,         33, "remu_100/7"};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_special();
        vec_t v[4];
        v[0] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0"};
        v[1] = '{3'b111, 32'd5,         32'd0,         32'd5,         1, "remu_by0"};
        v[2] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"};
        v[3] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf"};
        for (int i = 0; i < 4; i++) run_table(v[i]);
    endtask

    task automatic test_back_to_back();
        int dcyc, berr;
        logic [31:0] res;
        logic da;
        // start stays high through DONE; the next instruction starts in cycle 34
        issue_op(3'b101, 32'd1000, 32'd9, 1'b1, dcyc, res, berr, da);
        $display("[TB] b2b_first divu 1000/9 -> result=%h done_cycle=%0d", res, dcyc);
        n_tests++; if (res !== 32'd111) begin n_fail++; $display("FAIL b2b_first_result got %h expected 0000006f", res); end
        n_tests++; if (dcyc !== 33) begin n_fail++; $display("FAIL b2b_first_latency got %0d expected 33", dcyc); end
        issue_op(3'b111, 32'd1000, 32'd9, 1'b0, dcyc, res, berr, da);
        $display("[TB] b2b_second remu 1000/9 -> result=%h done_cycle=%0d", res, dcyc);
        n_tests++; if (res !== 32'd1) begin n_fail++; $display("FAIL b2b_second_result got %h expected 00000001", res); end
        n_tests++; if (dcyc !== 33) begin n_fail++; $display("FAIL b2b_second_latency got %0d expected 33", dcyc); end
        n_tests++; if (berr !== 0) begin n_fail++; $display("FAIL b2b_second_busy got %0d bad cycles expected 0", berr); end
    endtask

    task automatic test_flush();
        int dcyc, berr, seen_done;
        logic [31:0] res;
        logic da;
        // flush together with start in IDLE: not accepted
        @(posedge clk); #1;
        funct3 = 3'b100; op_a = 32'd5; op_b = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got %b expected 0", busy); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_idle_done got %b expected 0", done); end
        $display("[TB] flush_idle: start+flush ignored, done=%b", done);
        // flush in CALC at cycle 10; result (remu 1000/9 = 1) must be kept
        seen_done = 0;
        @(posedge clk); #1;
        funct3 = 3'b101; op_a = 32'hFFFF_FFFF; op_b = 32'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        #1;
        if (done === 1'b1) seen_done++;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_idle busy got %b expected 0", busy); end
        n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL flush_calc_done got %0d pulses expected 0", seen_done); end
        n_tests++; if (result !== 32'd1) begin n_fail++; $display("FAIL flush_calc_result got %h expected 00000001", result); end
        $display("[TB] flush_calc: divu ffffffff/3 killed at cycle 10, result=%h", result);
        // new start at cycle 12 completes at cycle 45
        issue_op(3'b101, 32'd100, 32'd7, 1'b0, dcyc, res, berr, da);
        $display("[TB] flush_restart divu 100/7 -> result=%h done_cycle=%0d", res, dcyc + 12);
        n_tests++; if (dcyc + 12 !== 45) begin n_fail++; $display("FAIL flush_restart_cycle got %0d expected 45", dcyc + 12); end
        n_tests++; if (res !== 32'd14) begin n_fail++; $display("FAIL flush_restart_result got %h expected 0000000e", res); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done got %b expected 0", done); end
        n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_mid_result got %h expected 00000000", result); end
        $display("[TB] reset_mid: busy=%b done=%b result=%h", busy, done, result);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_after_busy got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "timeout");
    end

endmodule
